// File: rtl/fft_frame_sequencer_pkg.sv
// fft_pkg: shared types, defaults and helpers for the FFT frame sequencer.
//   state_e          : sequencer states (GAP only reachable with FRAME_GAP_EN)
//   DEF_MIN/MAX_LOG2 : default legal transform size range (log2)
//   NFFT_LSB/NFFT_W  : transform-size field of the config word
//   FWD_BIT          : forward-direction flag of the config word
//   clamp_log2       : clamps a requested log2(N) into [lo, hi]
//   frame_last_idx   : frame-size decoder, returns N-1 at sample-counter width
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } state_e;

  localparam int DEF_MIN_LOG2 = 3;
  localparam int DEF_MAX_LOG2 = 11;

  localparam int CFG_W    = 16;
  localparam int NFFT_LSB = 0;
  localparam int NFFT_W   = 5;
  localparam int FWD_BIT  = 8;
  localparam int SCNT_W   = 11;

  function automatic logic [NFFT_W-1:0] clamp_log2(input logic [3:0] req,
                                                   input int unsigned lo,
                                                   input int unsigned hi);
    logic [NFFT_W-1:0] r;
    r = {1'b0, req};
    if (r < NFFT_W'(lo)) return NFFT_W'(lo);
    if (r > NFFT_W'(hi)) return NFFT_W'(hi);
    return r;
  endfunction

  // 12-bit intermediate so N=2048 is representable before subtracting 1.
  function automatic logic [SCNT_W-1:0] frame_last_idx(input logic [NFFT_W-1:0] log2_n);
    logic [SCNT_W:0] n;
    n = (SCNT_W+1)'(1) << log2_n;
    return SCNT_W'(n - (SCNT_W+1)'(1));
  endfunction

endpackage

// File: rtl/fft_frame_sequencer_cfg_encoder.sv
// fft_cfg_encoder: combinational clamp + pack of a requested transform setup
// into the 16-bit FFT config word. The same word is compared against the
// latched config to detect a size/direction change.
//   frame_size : requested log2(N), clamped to [MIN_LOG2, MAX_LOG2]
//   inverse    : 1 = inverse transform
//   cfg_word   : [4:0] clamped log2(N), [8] = ~inverse, other bits 0
module fft_cfg_encoder
  import fft_pkg::*;
#(
  parameter int MIN_LOG2 = DEF_MIN_LOG2,
  parameter int MAX_LOG2 = DEF_MAX_LOG2
) (
  input  logic [3:0]       frame_size,
  input  logic             inverse,
  output logic [CFG_W-1:0] cfg_word
);

  always_comb begin
    cfg_word = '0;
    cfg_word[NFFT_LSB +: NFFT_W] = clamp_log2(frame_size, MIN_LOG2, MAX_LOG2);
    cfg_word[FWD_BIT] = ~inverse;
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: sits between the sample FIFO and the FFT core. Issues
// the FFT config word, passes only whole frames, raises tLast on the last
// sample of each frame and counts completed frames. Size/direction changes
// and stop requests take effect only on frame boundaries.
// Optional: define FRAME_GAP_EN to insert GAP_CYCLES idle cycles after
// every frame (decision inputs are then sampled on the last gap cycle).
//   CLK, RST          : clock, synchronous active-high reset
//   run               : level, 1 = stream frames, 0 = stop at next boundary
//   frameSize/inverse : requested transform setup
//   cfgData/cfgValid/cfgReady : config channel to the FFT
//   srcValid/srcReady : sample FIFO side (srcReady is the pop enable)
//   fftValid/fftReady/tLast   : FFT data side
//   frameDone         : one-cycle pulse after a frame's last beat
//   busy              : sequencer not idle
//   frameCount        : completed frames since reset, wraps
//
// state  | meaning
// IDLE   | waiting for run
// CONFIG | config word presented, waiting for cfgReady
// STREAM | passing samples, counting toward N-1
// GAP    | idle spacing after a frame (FRAME_GAP_EN only)
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int MIN_LOG2   = DEF_MIN_LOG2,
  parameter int MAX_LOG2   = DEF_MAX_LOG2,
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic [3:0]       frameSize,
  input  logic             inverse,
  output logic [CFG_W-1:0] cfgData,
  output logic             cfgValid,
  input  logic             cfgReady,
  input  logic             srcValid,
  output logic             srcReady,
  output logic             fftValid,
  input  logic             fftReady,
  output logic             tLast,
  output logic             frameDone,
  output logic             busy,
  output logic [CNT_W-1:0] frameCount
);

  if (GAP_CYCLES < 1 || MIN_LOG2 > MAX_LOG2 || MAX_LOG2 > 11) begin : g_bad_params
    $error("fft_frame_sequencer: illegal parameter combination");
  end

  localparam logic [CFG_W-1:0] CFG_RST =
    CFG_W'(MIN_LOG2 << NFFT_LSB) | (CFG_W'(1) << FWD_BIT);

  state_e            state_q, state_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d, cfg_new;
  logic [SCNT_W-1:0] cnt_q, cnt_d, last_idx;
  logic [CNT_W-1:0]  frame_count_q, frame_count_d;
  logic              cfg_valid_q, cfg_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              streaming, beat, at_last, decide;

`ifdef FRAME_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0]  gap_q, gap_d;
`endif

  fft_cfg_encoder #(
    .MIN_LOG2 (MIN_LOG2),
    .MAX_LOG2 (MAX_LOG2)
  ) u_cfg_enc (
    .frame_size (frameSize),
    .inverse    (inverse),
    .cfg_word   (cfg_new)
  );

  assign last_idx  = frame_last_idx(cfg_q[NFFT_LSB +: NFFT_W]);
  assign streaming = (state_q == STREAM);
  assign beat      = srcValid & fftReady & streaming;
  assign at_last   = (cnt_q == last_idx);

  assign srcReady   = fftReady & streaming;
  assign fftValid   = srcValid & streaming;
  assign tLast      = fftValid & at_last;
  assign cfgData    = cfg_q;
  assign cfgValid   = cfg_valid_q;
  assign frameDone  = frame_done_q;
  assign busy       = busy_q;
  assign frameCount = frame_count_q;

  always_comb begin
    state_d       = state_q;
    cfg_d         = cfg_q;
    cnt_d         = cnt_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    decide        = 1'b0;
`ifdef FRAME_GAP_EN
    gap_d         = gap_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (run) begin
          cfg_d   = cfg_new;
          state_d = CONFIG;
        end
      end
      CONFIG: begin
        // run is deliberately ignored here; the handshake always completes.
        if (cfg_valid_q && cfgReady) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (beat) begin
          if (at_last) begin
            cnt_d         = '0;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 1'b1;
`ifdef FRAME_GAP_EN
            state_d = GAP;
            gap_d   = GAP_W'(GAP_CYCLES - 1);
`else
            decide  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef FRAME_GAP_EN
      GAP: begin
        if (gap_q == '0) decide = 1'b1;
        else             gap_d  = gap_q - 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Frame-boundary decision: stop, reconfigure, or keep streaming.
    if (decide) begin
      if (!run) begin
        state_d = IDLE;
      end else if (cfg_new != cfg_q) begin
        cfg_d   = cfg_new;
        state_d = CONFIG;
      end else begin
        state_d = STREAM;
      end
    end

    cfg_valid_d = (state_d == CONFIG);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      cfg_q         <= CFG_RST;
      cnt_q         <= '0;
      frame_count_q <= '0;
      cfg_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
`ifdef FRAME_GAP_EN
      gap_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cfg_q         <= cfg_d;
      cnt_q         <= cnt_d;
      frame_count_q <= frame_count_d;
      cfg_valid_q   <= cfg_valid_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
`ifdef FRAME_GAP_EN
      gap_q         <= gap_d;
`endif
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: directed scenarios followed by a randomized
// run, all checked every cycle against a behavioural model of the frame
// protocol, plus directed checks of frame boundaries and config words.
module tb_fft_frame_sequencer;

  localparam int CNT_W      = 4;
  localparam int GAP_CYCLES = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             run = 1'b0;
  logic [3:0]       frameSize = 4'd0;
  logic             inverse = 1'b0;
  logic             cfgReady = 1'b0;
  logic             srcValid = 1'b0;
  logic             fftReady = 1'b0;
  logic [15:0]      cfgData;
  logic             cfgValid, srcReady, fftValid, tLast, frameDone, busy;
  logic [CNT_W-1:0] frameCount;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  fft_frame_sequencer #(
    .MIN_LOG2   (3),
    .MAX_LOG2   (11),
    .CNT_W      (CNT_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .run        (run),
    .frameSize  (frameSize),
    .inverse    (inverse),
    .cfgData    (cfgData),
    .cfgValid   (cfgValid),
    .cfgReady   (cfgReady),
    .srcValid   (srcValid),
    .srcReady   (srcReady),
    .fftValid   (fftValid),
    .fftReady   (fftReady),
    .tLast      (tLast),
    .frameDone  (frameDone),
    .busy       (busy),
    .frameCount (frameCount)
  );

  // Model: 0 idle, 1 awaiting config accept, 2 streaming, 3 inter-frame gap.
  int               m_mode;
  logic [15:0]      m_cfg;
  int               m_beat;
  int               m_gap;
  logic [CNT_W-1:0] m_frames;
  logic             m_done;

  int          seg_beats;
  int          cyc_no = 0;
  int          cfgv_cycles;
  int          tlast_at[$];
  int          beat_cyc[$];
  logic [15:0] cfg_seen[$];
  bit          stall_toggle = 1'b0;

  function automatic logic [15:0] exp_word(input logic [3:0] fs, input logic inv);
    int l;
    l = int'(fs);
    if (l < 3)  l = 3;
    if (l > 11) l = 11;
    return 16'(l) | (inv ? 16'h0000 : 16'h0100);
  endfunction

  function automatic int n_of(input logic [15:0] w);
    return 1 << w[4:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tl(input string tag, input int idx, input int exp);
    chk(tag, (idx < tlast_at.size()) ? tlast_at[idx] : -1, exp);
  endtask

  task automatic model_reset();
    m_mode = 0; m_cfg = 16'h0103; m_beat = 0; m_frames = '0; m_done = 1'b0;
  endtask

  task automatic seg_start();
    seg_beats = 0; cfgv_cycles = 0;
    tlast_at.delete(); beat_cyc.delete(); cfg_seen.delete();
  endtask

  task automatic decide();
    logic [15:0] w;
    if (!run) m_mode = 0;
    else begin
      w = exp_word(frameSize, inverse);
      if (w != m_cfg) begin m_cfg = w; m_mode = 1; end
      else m_mode = 2;
    end
  endtask

  // Called at a negedge with inputs already applied; checks, then steps one clock.
  task automatic cycle();
    logic strm, bt;
    int   n;
    if (stall_toggle) fftReady = ~fftReady;
    #1;
    n    = n_of(m_cfg);
    strm = (m_mode == 2);
    bt   = srcValid & fftReady & strm;
    chk("srcReady",   srcReady,   fftReady & strm);
    chk("fftValid",   fftValid,   srcValid & strm);
    chk("tLast",      tLast,      (srcValid & strm) && (m_beat == n - 1));
    chk("cfgValid",   cfgValid,   m_mode == 1);
    chk("cfgData",    cfgData,    m_cfg);
    chk("busy",       busy,       m_mode != 0);
    chk("frameDone",  frameDone,  m_done);
    chk("frameCount", frameCount, m_frames);
    if (cfgValid) cfgv_cycles++;
    if (cfgValid && cfgReady) cfg_seen.push_back(cfgData);
    if (bt) begin
      seg_beats++;
      beat_cyc.push_back(cyc_no);
      if (tLast) tlast_at.push_back(seg_beats);
    end
    m_done = 1'b0;
    if (RST) model_reset();
    else begin
      case (m_mode)
        0: if (run) begin m_cfg = exp_word(frameSize, inverse); m_mode = 1; end
        1: if (cfgReady) begin m_mode = 2; m_beat = 0; end
        2: if (bt) begin
             if (m_beat == n - 1) begin
               m_beat = 0; m_done = 1'b1; m_frames = m_frames + 1'b1;
`ifdef FRAME_GAP_EN
               m_mode = 3; m_gap = GAP_CYCLES;
`else
               decide();
`endif
             end else m_beat++;
           end
        3: begin m_gap--; if (m_gap == 0) decide(); end
        default: m_mode = 0;
      endcase
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc_no++;
  endtask

  task automatic run_beats(input int n);
    int target, lim;
    target = seg_beats + n;
    lim = 0;
    while (seg_beats < target && lim < 6000) begin
      cycle();
      lim++;
    end
    chk("beats_reached", seg_beats, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_gap;
    repeat (2) @(negedge CLK);
    model_reset();

    // Reset state with data-side inputs asserted.
    srcValid = 1'b1; fftReady = 1'b1; run = 1'b1;
    cycle(); cycle();
    chk("rst_cfgData", cfgData, 16'h0103);
    chk("rst_busy", busy, 1'b0);
    chk("rst_srcReady", srcReady, 1'b0);

    // Basic 8-point frames.
    RST = 1'b0; frameSize = 4'd3; inverse = 1'b0; cfgReady = 1'b1;
    seg_start();
    run_beats(24);
    chk_tl("basic_tl0", 0, 8);
    chk_tl("basic_tl1", 1, 16);
    chk_tl("basic_tl2", 2, 24);
    chk("basic_cfgv_cycles", cfgv_cycles, 1);
    chk("basic_cfg_word", cfg_seen.size() > 0 ? cfg_seen[0] : 16'hFFFF, 16'h0103);
    chk("basic_frameCount", frameCount, 3);
    chk("basic_frameDone", frameDone, 1'b1);

    // Stop at beat 3 of the next frame.
    run_beats(3);
    run = 1'b0;
    run_beats(5);
    chk_tl("stop_tl", 3, 32);
    cycle(); cycle();
    chk("stop_busy", busy, 1'b0);
    chk("stop_srcReady", srcReady, 1'b0);

    // Stall: fftReady toggles every cycle, 16-point frames.
    frameSize = 4'd4; run = 1'b1; stall_toggle = 1'b1;
    seg_start();
    run_beats(16);
    run = 1'b0;
    run_beats(16);
    stall_toggle = 1'b0; fftReady = 1'b1;
    cycle(); cycle();
    chk("stall_n_tlast", tlast_at.size(), 2);
    chk_tl("stall_tl0", 0, 16);
    chk_tl("stall_tl1", 1, 32);

    // Mid-frame size change 4 -> 5.
    frameSize = 4'd4; run = 1'b1;
    seg_start();
    run_beats(5);
    frameSize = 4'd5;
    run_beats(11);
    run_beats(32);
    run = 1'b0;
    run_beats(32);
    cycle(); cycle();
    chk_tl("chg_tl0", 0, 16);
    chk_tl("chg_tl1", 1, 48);
    chk_tl("chg_tl2", 2, 80);
    chk("chg_cfg_n", cfg_seen.size(), 2);
    chk("chg_cfg1", cfg_seen.size() > 1 ? cfg_seen[1] : 16'hFFFF, 16'h0105);

    // Config backpressure with clamping of frameSize=15.
    frameSize = 4'd15; cfgReady = 1'b0; run = 1'b1;
    seg_start();
    repeat (12) cycle();
    chk("bp_cfgValid", cfgValid, 1'b1);
    chk("bp_cfgData", cfgData, 16'h010B);
    chk("bp_cfgv_cycles", cfgv_cycles, 11);
    chk("bp_no_beats", seg_beats, 0);
    cfgReady = 1'b1; run = 1'b0;
    run_beats(2048);
    chk_tl("bp_tl0", 0, 2048);
    cycle(); cycle();
    chk("bp_busy", busy, 1'b0);

    // Reset in the middle of a 16-point frame.
    frameSize = 4'd4; run = 1'b1;
    seg_start();
    run_beats(6);
    RST = 1'b1;
    cycle();
    chk("mrst_frameCount", frameCount, 0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_cfgValid", cfgValid, 1'b0);
    chk("mrst_cfgData", cfgData, 16'h0103);
    chk("mrst_fftValid", fftValid, 1'b0);
    RST = 1'b0;
    cycle();
    chk("mrst_restart_cfgValid", cfgValid, 1'b1);
    chk("mrst_restart_cfgData", cfgData, 16'h0104);
    run = 1'b0;
    run_beats(16);
    cycle(); cycle();

    // Spacing between two frames with the same configuration.
    frameSize = 4'd3; inverse = 1'b1; run = 1'b1;
    seg_start();
    run_beats(9);
`ifdef FRAME_GAP_EN
    exp_gap = GAP_CYCLES + 1;
`else
    exp_gap = 1;
`endif
    chk("frame_spacing", beat_cyc.size() > 8 ? beat_cyc[8] - beat_cyc[7] : -1, exp_gap);
    chk("inv_cfg_word", cfg_seen.size() > 0 ? cfg_seen[0] : 16'hFFFF, 16'h0003);
    run = 1'b0;
    run_beats(7);
    cycle(); cycle();

    // Randomized traffic, configuration churn and occasional resets.
    run = 1'b1;
    seg_start();
    for (int i = 0; i < 4000; i++) begin
      srcValid = ($urandom_range(0, 9) < 7);
      fftReady = ($urandom_range(0, 9) < 7);
      cfgReady = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) < 3) run = ~run;
      if ($urandom_range(0, 99) < 5)
        frameSize = ($urandom_range(0, 99) < 3) ? 4'($urandom_range(8, 15))
                                                : 4'($urandom_range(0, 6));
      if ($urandom_range(0, 99) < 4) inverse = ~inverse;
      RST = ($urandom_range(0, 999) < 2);
      cycle();
    end
    RST = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Controller between the sample FIFO and the FFT core.
- Issues the FFT configuration word (transform size, direction) on the config channel.
- Gates the sample stream so the FFT only sees whole frames, counts samples and generates tLast at each frame boundary.
- Applies frameSize/inverse changes only at frame boundaries; a stop request always ends on a boundary, never mid-frame.

Parameters:
- MIN_LOG2, 3, smallest legal transform log2 (N=8); lower codes clamp up.
- MAX_LOG2, 11, largest legal transform log2 (N=2048); higher codes clamp down.
- CNT_W, 16, width of the completed-frame counter.
- GAP_CYCLES, 4, idle cycles between frames; used only with FRAME_GAP_EN.

Ports:
- CLK  in  1  single clock; everything is on posedge.
- RST  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = stream frames, 0 = stop at the next frame boundary.
- frameSize  in  4  requested log2(N); clamped to [MIN_LOG2, MAX_LOG2].
- inverse  in  1  1 = inverse transform.
- cfgData  out  16  [4:0] = latched log2(N), [8] = ~inverse (FWD=1), all other bits 0.
- cfgValid  out  1  config word valid.
- cfgReady  in  1  FFT accepts config.
- srcValid  in  1  FIFO has a sample.
- srcReady  out  1  FIFO pop enable = fftReady & streaming.
- fftValid  out  1  = srcValid & streaming.
- fftReady  in  1  FFT tReady.
- tLast  out  1  = fftValid & (sampleCnt == N-1).
- frameDone  out  1  one-cycle pulse after the last beat of a frame transfers.
- busy  out  1  state != IDLE.
- frameCount  out  CNT_W  completed frames since reset; wraps.

Behaviour:
- Beat = srcValid & fftReady & streaming, where streaming = (state == STREAM).
- States: IDLE, CONFIG, STREAM, plus GAP when FRAME_GAP_EN is defined.
- IDLE:
  - run=1 → latch clamped frameSize and inverse into cfgReg; go to CONFIG.
  - run=0 → stay.
- CONFIG:
  - cfgValid=1 (registered from state); cfgData is driven from cfgReg and held stable.
  - cfgValid & cfgReady → STREAM, sampleCnt=0.
  - run falling while in CONFIG is ignored; the handshake completes first.
- STREAM:
  - Each beat increments sampleCnt (11 bits).
  - On the beat with sampleCnt == N-1: sampleCnt←0, frameDone←1 next cycle, frameCount+1.
  - Next state after that beat:
    - run=0 → IDLE.
    - clamp(frameSize), inverse differs from cfgReg → latch new value, go to CONFIG.
    - otherwise → stay in STREAM with no bubble.
- Inputs frameSize, inverse and run are sampled only at IDLE exit and at the last beat of a frame.
- Stall: srcValid=0 or fftReady=0 holds sampleCnt; no timeout.
- Combinational paths: fftValid, srcReady and tLast are combinational from registered state and the inputs; no added latency on the data path.
- Latency:
  - run high at edge k → cfgValid high from cycle k+1.
  - cfgReady accepted at edge m → first beat possible in cycle m+1.
- Reset (RST=1 at any edge, including mid-frame or mid-CONFIG):
  - state=IDLE, sampleCnt=0, frameCount=0, cfgReg={MIN_LOG2, fwd}.
  - All outputs 0, except cfgData, which reflects cfgReg.
  - The partial frame is discarded; the FFT core is reset by the same RST.
- frameCount wraps from 2^CNT_W-1 to 0.
- N = 1 << log2; the comparison uses N-1 at 11-bit width.

Optional Feature:
- Macro: FRAME_GAP_EN.
- Defined:
  - After each frame's last beat, enter GAP for GAP_CYCLES cycles with streaming=0 (srcReady=fftValid=0).
  - Then evaluate the run and config-change decision from STREAM.
  - The decision inputs are sampled at the last GAP cycle, not at the last beat.
- Undefined: the GAP state and its counter are absent; frames are back-to-back.

Decomposition:
- Shared package fft_pkg holds:
  - state enum: IDLE, CONFIG, STREAM, GAP;
  - MIN_LOG2/MAX_LOG2 defaults;
  - cfgData bit-field constants (NFFT_LSB=0, NFFT_W=5, FWD_BIT=8);
  - the log2 clamp function.
- The existing frame-size decoder is reused for N.
- One natural sub-module: fft_cfg_encoder. It is combinational clamp+pack of {frameSize, inverse} → 16-bit word, also used by the compare logic.

Test Plan:
- Basic: run=1, frameSize=3, cfgReady=1, srcValid=fftReady=1 → one cfgValid cycle with cfgData=0x0103; tLast on beats 8, 16, 24; frameCount increments each frame.
- Stall: frameSize=4, fftReady toggles 1,0 → tLast only on the 16th accepted beat; sampleCnt holds while fftReady=0.
- Mid-frame change: frameSize 4→5 at beat 5 → the current frame still ends at beat 16; a new CONFIG with cfgData=0x0105 follows; the next frame is 32 beats.
- Stop: run=0 at beat 3 of an 8-point frame → 5 more beats, tLast, then IDLE with busy=0 and srcReady=0.
- Config backpressure/clamp: frameSize=15, cfgReady held 0 for 10 cycles → cfgValid stays 1 with stable cfgData=0x010B; no srcReady until acceptance.
- Reset mid-frame: RST at beat 6 of a 16-point frame → next cycle all outputs 0, frameCount=0, state IDLE; run restarts at CONFIG. With FRAME_GAP_EN, check exactly 4 idle cycles between frames.
